// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order writeback result vs. buffered auxiliary results.
// Optional same-cycle bypass of idle slots when WB_ARB_BYPASS_EN is defined.
module wb_port_arbiter #(
  parameter int D_WIDTH      = 32,
  parameter int A_WIDTH      = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_write_w,
  input  logic [A_WIDTH-1:0] rd_w,
  input  logic [D_WIDTH-1:0] result_w,
  input  logic               aux_valid,
  output logic               aux_ready,
  input  logic [A_WIDTH-1:0] aux_rd,
  input  logic [D_WIDTH-1:0] aux_data,
  output logic               rf_we,
  output logic [A_WIDTH-1:0] rf_addr,
  output logic [D_WIDTH-1:0] rf_wd,
  output logic               stall_req,
  output logic               aux_pending
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [A_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
  logic [A_WIDTH-1:0] rd_mem_d   [FIFO_DEPTH];
  logic [D_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [D_WIDTH-1:0] data_mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [SW-1:0]      starve_q, starve_d;

  logic               pipe_req;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               bypass;
  logic [A_WIDTH-1:0] head_rd;
  logic [D_WIDTH-1:0] head_data;

  assign pipe_req   = reg_write_w && (rd_w != '0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign head_rd    = rd_mem_q[rd_ptr_q];
  assign head_data  = data_mem_q[rd_ptr_q];

  // Grant: forced slot, then pipeline, then buffered head, then (optionally) bypass.
  always_comb begin
    stall_req   = !rst && (starve_q == SW'(STARVE_LIMIT));
    aux_ready   = !rst && !fifo_full;
    aux_pending = !rst && !fifo_empty;
    pop         = 1'b0;
    bypass      = 1'b0;
    rf_we       = 1'b0;
    rf_addr     = rd_w;
    rf_wd       = result_w;
    if (!rst) begin
      if (stall_req) begin
        pop     = !fifo_empty;
        rf_we   = !fifo_empty && (head_rd != '0);
        rf_addr = head_rd;
        rf_wd   = head_data;
      end else if (pipe_req) begin
        rf_we   = 1'b1;
      end else if (!fifo_empty) begin
        pop     = 1'b1;
        rf_we   = (head_rd != '0);
        rf_addr = head_rd;
        rf_wd   = head_data;
      end
`ifdef WB_ARB_BYPASS_EN
      else if (aux_valid) begin
        bypass  = 1'b1;
        rf_we   = (aux_rd != '0);
        rf_addr = aux_rd;
        rf_wd   = aux_data;
      end
`endif
    end
    push = aux_valid && aux_ready && !bypass;
  end

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = aux_rd;
      data_mem_d[wr_ptr_q] = aux_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Starvation only accrues while an entry sits in the buffer without being served.
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model plus directed scenarios.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_write_w = 1'b0;
  logic [4:0]  rd_w = '0;
  logic [31:0] result_w = '0;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_rd = '0;
  logic [31:0] aux_data = '0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic        stall_req;
  logic        aux_pending;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.D_WIDTH(32), .A_WIDTH(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd), .stall_req(stall_req),
    .aux_pending(aux_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of buffered results and a count of lost cycles.
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;
  ent_t mq[$];
  int   m_starve = 0;

  always @(negedge clk) begin : model
    bit          pipe, e_we, e_rdy, e_stall, e_pend, e_pop, e_byp;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    int          n0;
    pipe    = reg_write_w && (rd_w != 0);
    n0      = mq.size();
    e_we    = 0; e_pop = 0; e_byp = 0; e_addr = '0; e_wd = '0;
    e_stall = !rst && (m_starve >= LIMIT);
    e_rdy   = !rst && (n0 < DEPTH);
    e_pend  = !rst && (n0 > 0);
    if (!rst) begin
      if ((e_stall || !pipe) && n0 > 0) begin
        e_pop = 1; e_we = (mq[0].rd != 0); e_addr = mq[0].rd; e_wd = mq[0].data;
      end else if (pipe) begin
        e_we = 1; e_addr = rd_w; e_wd = result_w;
      end
`ifdef WB_ARB_BYPASS_EN
      else if (aux_valid) begin
        e_byp = 1; e_we = (aux_rd != 0); e_addr = aux_rd; e_wd = aux_data;
      end
`endif
    end
    chk("m_rf_we", rf_we, e_we);
    chk("m_stall_req", stall_req, e_stall);
    chk("m_aux_ready", aux_ready, e_rdy);
    chk("m_aux_pending", aux_pending, e_pend);
    if (e_we) begin
      chk("m_rf_addr", rf_addr, e_addr);
      chk("m_rf_wd", rf_wd, e_wd);
    end
    if (rst) begin
      mq.delete();
      m_starve = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (aux_valid && e_rdy && !e_byp) mq.push_back({aux_rd, aux_data});
      if (n0 == 0 || e_pop) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    int seen;
    bit acc;

    // Reset held with requests asserted: nothing may leak out or be captured.
    rst = 1; aux_valid = 1; aux_rd = 5'd8; aux_data = 32'h88;
    reg_write_w = 1; rd_w = 5'd3; result_w = 32'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_aux_ready", aux_ready, 0);
      chk("rst_aux_pending", aux_pending, 0);
      cyc();
    end
    rst = 0; aux_valid = 0; reg_write_w = 0;
    @(negedge clk);
    chk("post_rst_pending", aux_pending, 0);
    cyc();

    // Single aux result into an idle pipeline.
    aux_valid = 1; aux_rd = 5'd5; aux_data = 32'hDEADBEEF;
    @(negedge clk);
`ifdef WB_ARB_BYPASS_EN
    chk("idle_c0_we", rf_we, 1);
    chk("idle_c0_addr", rf_addr, 5);
    chk("idle_c0_wd", rf_wd, 32'hDEADBEEF);
`else
    chk("idle_c0_we", rf_we, 0);
    chk("idle_c0_ready", aux_ready, 1);
`endif
    cyc();
    aux_valid = 0;
    @(negedge clk);
`ifdef WB_ARB_BYPASS_EN
    chk("idle_c1_we", rf_we, 0);
    chk("idle_c1_pend", aux_pending, 0);
`else
    chk("idle_c1_we", rf_we, 1);
    chk("idle_c1_addr", rf_addr, 5);
    chk("idle_c1_wd", rf_wd, 32'hDEADBEEF);
    chk("idle_c1_pend", aux_pending, 1);
`endif
    cyc();
    @(negedge clk);
    chk("idle_c2_pend", aux_pending, 0);
    cyc();

    // Pipeline beats buffered entry; x0 pipeline write yields the slot.
    reg_write_w = 1; rd_w = 5'd2; result_w = 32'h10;
    aux_valid = 1; aux_rd = 5'd7; aux_data = 32'h22;
    cyc();
    aux_valid = 0; rd_w = 5'd3; result_w = 32'h11;
    @(negedge clk);
    chk("prio_pipe_addr", rf_addr, 3);
    chk("prio_pipe_wd", rf_wd, 32'h11);
    chk("prio_pend", aux_pending, 1);
    cyc();
    rd_w = 5'd0; result_w = 32'h99;
    @(negedge clk);
    chk("prio_aux_we", rf_we, 1);
    chk("prio_aux_addr", rf_addr, 7);
    chk("prio_aux_wd", rf_wd, 32'h22);
    cyc();
    reg_write_w = 0;
    @(negedge clk);
    chk("prio_drained", aux_pending, 0);
    cyc();

    // Starvation: continuous pipeline with one buffered entry.
    reg_write_w = 1; rd_w = 5'd10; result_w = 32'hA0;
    aux_valid = 1; aux_rd = 5'd9; aux_data = 32'h99;
    cyc();
    aux_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      rd_w = 5'(10 + i); result_w = 32'hA0 + 32'(i);
      @(negedge clk);
      if (i < 5) chk("starve_no_stall", stall_req, 0);
      else begin
        chk("starve_stall", stall_req, 1);
        chk("starve_forced_addr", rf_addr, 9);
        chk("starve_forced_wd", rf_wd, 32'h99);
      end
      cyc();
    end
    @(negedge clk);
    chk("held_we", rf_we, 1);
    chk("held_addr", rf_addr, 15);
    chk("held_wd", rf_wd, 32'hA5);
    chk("held_no_stall", stall_req, 0);
    chk("held_pend", aux_pending, 0);
    cyc();
    reg_write_w = 0;
    cyc();

    // Fill the buffer under continuous pipeline; drain in order via forced slots.
    reg_write_w = 1; rd_w = 5'd20; result_w = 32'h20;
    aux_valid = 1; aux_rd = 5'd21; aux_data = 32'h121;
    cyc();
    aux_rd = 5'd22; aux_data = 32'h122;
    cyc();
    aux_rd = 5'd23; aux_data = 32'h123;
    seen = 0;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("full_ready", aux_ready, 0);
      if (rf_we && rf_addr >= 5'd21 && rf_addr <= 5'd23) begin
        chk("drain_order", rf_addr, 32'(21 + seen));
        seen++;
      end
      acc = aux_valid && aux_ready;
      cyc();
      if (acc) aux_valid = 0;
    end
    if (seen < 3) chk("drain_timeout", seen, 3);
    reg_write_w = 0;
    cyc();

    // Aux result to x0: consumed, never written.
    aux_valid = 1; aux_rd = 5'd0; aux_data = 32'hFFFF;
    @(negedge clk);
    chk("x0_c0_we", rf_we, 0);
    cyc();
    aux_valid = 0;
    @(negedge clk);
    chk("x0_c1_we", rf_we, 0);
`ifndef WB_ARB_BYPASS_EN
    chk("x0_c1_pend", aux_pending, 1);
`endif
    cyc();
    @(negedge clk);
    chk("x0_c2_pend", aux_pending, 0);
    cyc();

    // Reset mid-operation discards the buffered entry.
    reg_write_w = 1; rd_w = 5'd4; result_w = 32'h44;
    aux_valid = 1; aux_rd = 5'd6; aux_data = 32'h66;
    cyc();
    aux_valid = 0; rst = 1;
    @(negedge clk);
    chk("midrst_we", rf_we, 0);
    chk("midrst_pend", aux_pending, 0);
    cyc();
    rst = 0; reg_write_w = 0;
    @(negedge clk);
    chk("midrst_discard", aux_pending, 0);
    chk("midrst_no_write", rf_we, 0);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback result and a long-latency auxiliary unit (divider, or a load completing out of band).
- The auxiliary unit returns results with a valid/ready handshake. Those results are buffered in a small FIFO and written in idle writeback slots.
- A starvation counter forces a pipeline hold so buffered results are never blocked indefinitely.
- Sits between the writeback-stage result mux and the register file. Also feeds the hazard unit.

Parameters:
D_WIDTH, 32, data width of result/register-file write data
A_WIDTH, 5, register address width
FIFO_DEPTH, 2, auxiliary result buffer entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive lost-arbitration cycles before forced hold (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
reg_write_w  input  1  pipeline writeback enable
rd_w  input  A_WIDTH  pipeline destination register
result_w  input  D_WIDTH  pipeline writeback data
aux_valid  input  1  auxiliary result valid
aux_ready  output  1  FIFO can accept auxiliary result
aux_rd  input  A_WIDTH  auxiliary destination register
aux_data  input  D_WIDTH  auxiliary result data
rf_we  output  1  register-file write enable
rf_addr  output  A_WIDTH  register-file write address
rf_wd  output  D_WIDTH  register-file write data
stall_req  output  1  to hazard unit: hold W stage this cycle
aux_pending  output  1  FIFO non-empty (hazard unit blocks dependent issue)

Interface: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- **Reset (rst=1 at edge):**
  - FIFO emptied, pointers and count = 0, starve counter = 0.
  - While rst is high: rf_we=0, aux_ready=0, stall_req=0, aux_pending=0.
  - rf_addr/rf_wd are don't-care while rst is high.
- **Pipeline request:** pipe_req = reg_write_w && (rd_w != 0). A write to x0 is not a request.
- **Grant, evaluated combinationally each cycle:**
  - stall_req=1 -> FIFO head wins. rf_we=1 only if head rd!=0. Head is popped.
  - else pipe_req -> pipeline wins: rf_we=1, rf_addr=rd_w, rf_wd=result_w.
  - else FIFO non-empty -> head popped. rf_we = (head rd != 0), so an x0 entry is popped and discarded.
  - else rf_we=0.
- **Hold semantics:**
  - stall_req=1 obliges the hazard unit to hold the W-stage register.
  - Any pipeline write presented in that cycle is not performed and is re-presented next cycle, so it is never lost.
- **FIFO:**
  - aux_ready = !full. Push on aux_valid && aux_ready.
  - Push and pop in the same cycle are both performed (count unchanged). Pop when empty never occurs.
  - A result pushed at edge N is writable no earlier than cycle N+1.
  - Entries are written strictly in arrival order.
  - aux_pending = (count != 0), registered state only.
- **Starve counter:**
  - Cleared when the FIFO is empty or the head is popped.
  - Otherwise incremented, saturating at STARVE_LIMIT.
  - stall_req = (counter == STARVE_LIMIT) && !rst, so the forced slot occurs in the cycle after the limit-th lost cycle.
- **Boundaries:**
  - FIFO full with a simultaneous pop: aux_ready stays 0 in that cycle (no same-cycle refill).
  - Pointers wrap modulo FIFO_DEPTH.
  - Reset mid-operation discards all buffered results; the upstream unit must reissue.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- **Defined:** when the FIFO is empty, !pipe_req and aux_valid, the auxiliary result is written directly in the same cycle. In that case rf_we = (aux_rd != 0), rf_addr=aux_rd, rf_wd=aux_data, aux_ready=1, and there is no push. Zero-cycle latency in idle slots.
- **Undefined:** every auxiliary result passes through the FIFO, with minimum latency 1 cycle.

Test Plan:
- Reset held 3 cycles with aux_valid=1 and reg_write_w=1 -> rf_we=0, aux_ready=0, aux_pending=0 throughout. No push occurs.
- Idle pipeline; push aux rd=5, data=0xDEADBEEF at cycle 0 -> cycle 1: rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF, aux_pending falls after that edge. With WB_ARB_BYPASS_EN the write occurs in cycle 0 instead.
- Simultaneous pipeline write rd=3/0x11 and buffered aux rd=7/0x22 -> pipeline written first. Aux is written in the first cycle with reg_write_w=0 or rd_w=0.
- Continuous pipe_req with 1 buffered entry, STARVE_LIMIT=4:
  - stall_req=1 exactly in the 5th cycle; aux entry written then.
  - The pipeline write held that cycle is written the following cycle.
  - Counter back to 0.
- Fill FIFO (2 pushes) under continuous pipe_req -> aux_ready=0. Third aux_valid is held. Entries drain in order after forced slots.
- Aux write to rd=0 with data 0xFFFF -> entry popped, rf_we stays 0, aux_pending clears.
